// File: rtl/ysyx_23060240_pkg.sv
// Shared definitions for the CSR access sequencer: SYSTEM funct3 codes, implemented
// CSR addresses and the sequencer state encoding.
package ysyx_23060240_pkg;

  localparam logic [2:0] F3Priv = 3'b000;
  localparam logic [2:0] F3Rw   = 3'b001;
  localparam logic [2:0] F3Rs   = 3'b010;
  localparam logic [2:0] F3Rc   = 3'b011;
  localparam logic [2:0] F3Rwi  = 3'b101;
  localparam logic [2:0] F3Rsi  = 3'b110;
  localparam logic [2:0] F3Rci  = 3'b111;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StTrap,
    StResp
  } state_e;

  function automatic logic csr_is_legal(input logic [11:0] addr);
    return (addr == CsrMstatus) || (addr == CsrMtvec) || (addr == CsrMepc) ||
           (addr == CsrMcause);
  endfunction

endpackage

// File: rtl/ysyx_23060240_csr_alu.sv
// Combinational read-modify-write datapath: new CSR value for RW/RS/RC (and immediate
// forms) plus the write-suppress decision.
module ysyx_23060240_csr_alu
  import ysyx_23060240_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rs1_idx_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] old_val_i,
  input  logic            illegal_i,
  output logic [XLEN-1:0] new_val_o,
  output logic            suppress_o
);

  logic [XLEN-1:0] src;

  always_comb begin
    // Immediate forms reuse the rs1 field as a zero-extended 5-bit operand.
    src        = funct3_i[2] ? XLEN'(rs1_idx_i) : rs1_data_i;
    new_val_o  = '0;
    suppress_o = illegal_i;
    unique case (funct3_i)
      F3Rw, F3Rwi: new_val_o = src;
      F3Rs, F3Rsi: begin
        new_val_o = old_val_i | src;
        if (rs1_idx_i == 5'd0) suppress_o = 1'b1;
      end
      F3Rc, F3Rci: begin
        new_val_o = old_val_i & ~src;
        if (rs1_idx_i == 5'd0) suppress_o = 1'b1;
      end
      default: suppress_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_23060240_csr_ctrl.sv
// CSR access sequencer: one SYSTEM instruction at a time, read-modify-write for Zicsr
// ops and ecall/mret trap strobes with a PC redirect back to the core.
module ysyx_23060240_csr_ctrl
  import ysyx_23060240_pkg::*;
#(
  parameter int unsigned CSR_ADDR_W = 12,
  parameter int unsigned XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_funct3,
  input  logic                  in_is_mret,
  input  logic [CSR_ADDR_W-1:0] in_csr_addr,
  input  logic [4:0]            in_rs1_idx,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [4:0]            in_rd_idx,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  r_csr_en,
  output logic [CSR_ADDR_W-1:0] r_csr_addr,
  input  logic [XLEN-1:0]       r_csr_data,
  output logic                  w_csr_en,
  output logic [CSR_ADDR_W-1:0] w_csr_addr,
  output logic [XLEN-1:0]       w_csr_data,
  output logic                  jump_ecall,
  output logic                  jump_mret,
  output logic [XLEN-1:0]       pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_rd_idx,
  output logic                  out_rd_wen,
  output logic [XLEN-1:0]       out_rd_data,
  output logic                  out_redirect,
  output logic [XLEN-1:0]       out_target,
  output logic                  out_illegal
);

  state_e                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  is_mret_q, is_mret_d;
  logic [CSR_ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]            rs1_idx_q, rs1_idx_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [4:0]            rd_idx_q, rd_idx_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       old_q, old_d;
  logic                  rd_wen_q, rd_wen_d;
  logic [XLEN-1:0]       rd_data_q, rd_data_d;
  logic                  redirect_q, redirect_d;
  logic [XLEN-1:0]       target_q, target_d;
  logic                  illegal_q, illegal_d;

  logic                  illegal;
  logic [XLEN-1:0]       new_val;
  logic                  suppress;

  assign illegal = ~csr_is_legal(12'(addr_q));

  ysyx_23060240_csr_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .funct3_i  (funct3_q),
    .rs1_idx_i (rs1_idx_q),
    .rs1_data_i(rs1_data_q),
    .old_val_i (old_q),
    .illegal_i (illegal),
    .new_val_o (new_val),
    .suppress_o(suppress)
  );

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    is_mret_d  = is_mret_q;
    addr_d     = addr_q;
    rs1_idx_d  = rs1_idx_q;
    rs1_data_d = rs1_data_q;
    rd_idx_d   = rd_idx_q;
    pc_d       = pc_q;
    old_d      = old_q;
    rd_wen_d   = rd_wen_q;
    rd_data_d  = rd_data_q;
    redirect_d = redirect_q;
    target_d   = target_q;
    illegal_d  = illegal_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          funct3_d   = in_funct3;
          is_mret_d  = in_is_mret;
          addr_d     = in_csr_addr;
          rs1_idx_d  = in_rs1_idx;
          rs1_data_d = in_rs1_data;
          rd_idx_d   = in_rd_idx;
          pc_d       = in_pc;
          state_d    = (in_funct3 == F3Priv) ? StTrap : StRead;
        end
      end
      StRead: begin
        old_d   = r_csr_data;
        state_d = StWrite;
      end
      StWrite: begin
        rd_wen_d   = (rd_idx_q != 5'd0);
        rd_data_d  = illegal ? '0 : old_q;
        redirect_d = 1'b0;
        target_d   = '0;
        illegal_d  = illegal;
        state_d    = StResp;
      end
      StTrap: begin
        // r_csr_addr already selects mtvec/mepc, so the target is captured here.
        target_d   = r_csr_data;
        rd_wen_d   = 1'b0;
        rd_data_d  = '0;
        redirect_d = 1'b1;
        illegal_d  = 1'b0;
        state_d    = StResp;
      end
      StResp: begin
        if (out_ready) begin
          rd_wen_d   = 1'b0;
          rd_data_d  = '0;
          redirect_d = 1'b0;
          target_d   = '0;
          illegal_d  = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      funct3_q   <= '0;
      is_mret_q  <= 1'b0;
      addr_q     <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      rd_idx_q   <= '0;
      pc_q       <= '0;
      old_q      <= '0;
      rd_wen_q   <= 1'b0;
      rd_data_q  <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      is_mret_q  <= is_mret_d;
      addr_q     <= addr_d;
      rs1_idx_q  <= rs1_idx_d;
      rs1_data_q <= rs1_data_d;
      rd_idx_q   <= rd_idx_d;
      pc_q       <= pc_d;
      old_q      <= old_d;
      rd_wen_q   <= rd_wen_d;
      rd_data_q  <= rd_data_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
    r_csr_en   = (state_q == StRead);
    r_csr_addr = '0;
    if (state_q == StRead) begin
      r_csr_addr = addr_q;
    end else if (state_q == StTrap) begin
      r_csr_addr = is_mret_q ? CSR_ADDR_W'(CsrMepc) : CSR_ADDR_W'(CsrMtvec);
    end
    w_csr_en   = (state_q == StWrite) && !suppress;
    w_csr_addr = w_csr_en ? addr_q : '0;
    w_csr_data = w_csr_en ? new_val : '0;
    jump_ecall = (state_q == StTrap) && !is_mret_q;
    jump_mret  = (state_q == StTrap) && is_mret_q;
  end

  assign pc           = pc_q;
  assign out_valid    = (state_q == StResp);
  assign out_rd_idx   = rd_idx_q;
  assign out_rd_wen   = rd_wen_q;
  assign out_rd_data  = rd_data_q;
  assign out_redirect = redirect_q;
  assign out_target   = target_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_ysyx_23060240_csr_ctrl.sv
// Bench for the CSR sequencer: table of single-instruction vectors against a small CSR
// file model, scoreboarded results, plus backpressure and mid-operation reset sequences.
module tb_ysyx_23060240_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = '0;
  logic        in_is_mret = 1'b0;
  logic [11:0] in_csr_addr = '0;
  logic [4:0]  in_rs1_idx = '0;
  logic [31:0] in_rs1_data = '0;
  logic [4:0]  in_rd_idx = '0;
  logic [31:0] in_pc = '0;
  logic        r_csr_en;
  logic [11:0] r_csr_addr;
  logic [31:0] r_csr_data;
  logic        w_csr_en;
  logic [11:0] w_csr_addr;
  logic [31:0] w_csr_data;
  logic        jump_ecall, jump_mret;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_rd_idx;
  logic        out_rd_wen;
  logic [31:0] out_rd_data;
  logic        out_redirect;
  logic [31:0] out_target;
  logic        out_illegal;

  always #5 clk = ~clk;

  ysyx_23060240_csr_ctrl #(
    .CSR_ADDR_W(12),
    .XLEN      (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct3   (in_funct3),
    .in_is_mret  (in_is_mret),
    .in_csr_addr (in_csr_addr),
    .in_rs1_idx  (in_rs1_idx),
    .in_rs1_data (in_rs1_data),
    .in_rd_idx   (in_rd_idx),
    .in_pc       (in_pc),
    .r_csr_en    (r_csr_en),
    .r_csr_addr  (r_csr_addr),
    .r_csr_data  (r_csr_data),
    .w_csr_en    (w_csr_en),
    .w_csr_addr  (w_csr_addr),
    .w_csr_data  (w_csr_data),
    .jump_ecall  (jump_ecall),
    .jump_mret   (jump_mret),
    .pc          (pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd_idx  (out_rd_idx),
    .out_rd_wen  (out_rd_wen),
    .out_rd_data (out_rd_data),
    .out_redirect(out_redirect),
    .out_target  (out_target),
    .out_illegal (out_illegal)
  );

  // CSR file model: slot 4 absorbs anything unimplemented.
  logic [31:0] csr_mem [5];
  logic        preset_go = 1'b0;
  logic [11:0] preset_addr = '0;
  logic [31:0] preset_val = '0;
  int          w_cnt = 0, ecall_cnt = 0, mret_cnt = 0;
  logic [11:0] w_addr_seen = '0;
  logic [31:0] w_data_seen = '0, ecall_pc_seen = '0;

  function automatic int idx_of(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return 4;
    endcase
  endfunction

  always_comb begin
    r_csr_data = 32'hDEAD_BEEF;
    if (idx_of(r_csr_addr) != 4) r_csr_data = csr_mem[idx_of(r_csr_addr)];
  end

  always @(negedge clk) begin
    if (preset_go) csr_mem[idx_of(preset_addr)] <= preset_val;
    if (w_csr_en) begin
      w_cnt       <= w_cnt + 1;
      w_addr_seen <= w_csr_addr;
      w_data_seen <= w_csr_data;
      if (idx_of(w_csr_addr) != 4) csr_mem[idx_of(w_csr_addr)] <= w_csr_data;
    end
    if (jump_ecall) begin
      ecall_cnt     <= ecall_cnt + 1;
      ecall_pc_seen <= pc;
    end
    if (jump_mret) mret_cnt <= mret_cnt + 1;
  end

  typedef struct {
    logic [2:0]  f3;
    logic        mret;
    logic [11:0] addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic [4:0]  rd;
    logic [31:0] pcv;
    logic [31:0] init;
    logic        exp_w;
    logic [31:0] exp_wdata;
    logic        exp_wen;
    logic [31:0] exp_data;
    logic        exp_redir;
    logic [31:0] exp_target;
    logic        exp_ill;
    int          lat;
  } vec_t;

  vec_t vecs[11];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic [2:0] f3, input logic mret, input logic [11:0] addr,
                              input logic [4:0] rs1i, input logic [31:0] rs1d,
                              input logic [4:0] rd, input logic [31:0] pcv,
                              input logic [31:0] init, input logic ew, input logic [31:0] ewd,
                              input logic ewen, input logic [31:0] ed, input logic er,
                              input logic [31:0] et, input logic ei, input int lat);
    vec_t v;
    v = '{f3, mret, addr, rs1i, rs1d, rd, pcv, init, ew, ewd, ewen, ed, er, et, ei, lat};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_preset(input logic [11:0] a, input logic [31:0] val);
    @(posedge clk); #1;
    preset_addr = a;
    preset_val  = val;
    preset_go   = 1'b1;
    @(posedge clk); #1;
    preset_go = 1'b0;
  endtask

  task automatic drive(input logic [2:0] f3, input logic mret, input logic [11:0] addr,
                       input logic [4:0] rs1i, input logic [31:0] rs1d, input logic [4:0] rd,
                       input logic [31:0] pcv);
    in_valid    = 1'b1;
    in_funct3   = f3;
    in_is_mret  = mret;
    in_csr_addr = addr;
    in_rs1_idx  = rs1i;
    in_rs1_data = rs1d;
    in_rd_idx   = rd;
    in_pc       = pcv;
  endtask

  task automatic clear_inputs();
    in_valid    = 1'b0;
    in_funct3   = '0;
    in_is_mret  = 1'b0;
    in_csr_addr = '0;
    in_rs1_idx  = '0;
    in_rs1_data = '0;
    in_rd_idx   = '0;
    in_pc       = '0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int   w0, e0, m0, lat;
    vec_t e;
    string tag;
    tag = $sformatf("v%0d", id);
    do_preset(v.addr, v.init);
    w0 = w_cnt; e0 = ecall_cnt; m0 = mret_cnt;
    out_ready = 1'b1;
    drive(v.f3, v.mret, (v.f3 == 3'b000) ? 12'h000 : v.addr, v.rs1_idx, v.rs1_data, v.rd, v.pcv);
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    exp_q.push_back(v);
    @(posedge clk); #1;
    clear_inputs();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    e = exp_q.pop_front();
    if (out_valid) begin
      check({tag, " rd_idx"}, 32'(out_rd_idx), 32'(e.rd));
      check({tag, " rd_wen"}, 32'(out_rd_wen), 32'(e.exp_wen));
      check({tag, " rd_data"}, out_rd_data, e.exp_data);
      check({tag, " redirect"}, 32'(out_redirect), 32'(e.exp_redir));
      check({tag, " target"}, out_target, e.exp_target);
      check({tag, " illegal"}, 32'(out_illegal), 32'(e.exp_ill));
    end
    @(posedge clk); #1;
    check({tag, " write count"}, 32'(w_cnt - w0), 32'(e.exp_w));
    if (e.exp_w) begin
      check({tag, " write addr"}, 32'(w_addr_seen), 32'(e.addr));
      check({tag, " write data"}, w_data_seen, e.exp_wdata);
    end
    if (idx_of(e.addr) != 4)
      check({tag, " csr value"}, csr_mem[idx_of(e.addr)], e.exp_w ? e.exp_wdata : e.init);
    check({tag, " ecall strobes"}, 32'(ecall_cnt - e0),
          32'(e.f3 == 3'b000 && !e.mret));
    check({tag, " mret strobes"}, 32'(mret_cnt - m0), 32'(e.f3 == 3'b000 && e.mret));
    if (e.f3 == 3'b000 && !e.mret) check({tag, " ecall pc"}, ecall_pc_seen, e.pcv);
    @(negedge clk);
    check({tag, " idle after"}, {31'd0, in_ready} | {30'd0, out_valid, 1'b0}, 32'd1);
  endtask

  initial begin
    int w0, lat;
    for (int i = 0; i < 5; i++) csr_mem[i] = '0;

    //              f3      mret addr     rs1i   rs1d          rd     pc
    //              init          w     wdata         wen   data          redir target   ill lat
    vecs[0]  = mk(3'b001, 0, 12'h305, 5'd3,  32'h8000_0100, 5'd5,  32'h0,
                  32'h0,         1'b1, 32'h8000_0100, 1'b1, 32'h0,         0, 32'h0, 0, 3);
    vecs[1]  = mk(3'b010, 0, 12'h300, 5'd4,  32'h0000_0008, 5'd6,  32'h0,
                  32'h0000_1800, 1'b1, 32'h0000_1808, 1'b1, 32'h0000_1800, 0, 32'h0, 0, 3);
    vecs[2]  = mk(3'b011, 0, 12'h341, 5'd0,  32'hFFFF_FFFF, 5'd7,  32'h0,
                  32'h1234_5678, 1'b0, 32'h0,         1'b1, 32'h1234_5678, 0, 32'h0, 0, 3);
    vecs[3]  = mk(3'b011, 0, 12'h342, 5'd2,  32'h0000_000F, 5'd8,  32'h0,
                  32'h8000_000B, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_000B, 0, 32'h0, 0, 3);
    vecs[4]  = mk(3'b101, 0, 12'h300, 5'd31, 32'h0000_AAAA, 5'd0,  32'h0,
                  32'h0000_0088, 1'b1, 32'h0000_001F, 1'b0, 32'h0000_0088, 0, 32'h0, 0, 3);
    vecs[5]  = mk(3'b110, 0, 12'h305, 5'd3,  32'hFFFF_0000, 5'd9,  32'h0,
                  32'h0000_0100, 1'b1, 32'h0000_0103, 1'b1, 32'h0000_0100, 0, 32'h0, 0, 3);
    vecs[6]  = mk(3'b111, 0, 12'h341, 5'd5,  32'h0,         5'd1,  32'h0,
                  32'h0000_00FF, 1'b1, 32'h0000_00FA, 1'b1, 32'h0000_00FF, 0, 32'h0, 0, 3);
    vecs[7]  = mk(3'b110, 0, 12'h300, 5'd0,  32'hFFFF_FFFF, 5'd2,  32'h0,
                  32'h0000_0055, 1'b0, 32'h0,         1'b1, 32'h0000_0055, 0, 32'h0, 0, 3);
    vecs[8]  = mk(3'b001, 0, 12'h7C0, 5'd3,  32'h0000_1234, 5'd10, 32'h0,
                  32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         0, 32'h0, 1, 3);
    vecs[9]  = mk(3'b000, 0, 12'h305, 5'd0,  32'h0,         5'd0,  32'h8000_0040,
                  32'h8000_0200, 1'b0, 32'h0,         1'b0, 32'h0, 1, 32'h8000_0200, 0, 2);
    vecs[10] = mk(3'b000, 1, 12'h341, 5'd0,  32'h0,         5'd5,  32'h0,
                  32'h8000_0044, 1'b0, 32'h0,         1'b0, 32'h0, 1, 32'h8000_0044, 0, 2);

    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset strobes/flags",
          32'({r_csr_en, w_csr_en, jump_ecall, jump_mret, out_valid, out_rd_wen,
               out_redirect, out_illegal}), 32'd0);
    check("reset data", out_rd_data | out_target | pc | 32'(out_rd_idx), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Backpressure: result held while out_ready is low, no new accept.
    do_preset(12'h342, 32'h0000_0077);
    out_ready = 1'b0;
    drive(3'b001, 1'b0, 12'h342, 5'd4, 32'h0000_ABCD, 5'd3, 32'h0);
    @(posedge clk); #1;
    drive(3'b000, 1'b0, 12'h000, 5'd0, 32'h0, 5'd0, 32'h1111_0000);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("bp latency", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d valid/ready", k), {30'd0, out_valid, in_ready}, 32'd2);
      check($sformatf("bp hold%0d data", k), out_rd_data, 32'h0000_0077);
      check($sformatf("bp hold%0d rd", k), 32'({out_rd_idx, out_rd_wen, jump_ecall}),
            32'({5'd3, 1'b1, 1'b0}));
    end
    @(posedge clk); #1;
    clear_inputs();
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp release", {30'd0, out_valid, in_ready}, 32'd1);
    check("bp csr value", csr_mem[3], 32'h0000_ABCD);

    // Reset while the write strobe is up: nothing must reach the CSR file.
    do_preset(12'h300, 32'h0000_0011);
    drive(3'b001, 1'b0, 12'h300, 5'd4, 32'h0000_FFFF, 5'd4, 32'h0);
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    w0 = w_cnt;
    check("rst pre write strobe", 32'(w_csr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst async outputs",
          32'({w_csr_en, r_csr_en, out_valid, jump_ecall, jump_mret}), 32'd0);
    check("rst async ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst no write", 32'(w_cnt - w0), 32'd0);
    check("rst csr intact", csr_mem[0], 32'h0000_0011);
    check("rst latched cleared", 32'(out_rd_idx) | out_rd_data | pc, 32'd0);
    check("rst idle", {30'd0, out_valid, in_ready}, 32'd1);

    vecs[1].init     = 32'h0000_0011;
    vecs[1].exp_data = 32'h0000_0011;
    vecs[1].exp_wdata = 32'h0000_0019;
    run_vec(11, vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
